mod_symbol_scheduler: RTL and testbench

Symbol-level controller for the digital modulator's carrier generator. It accepts serial data bits over a valid/ready handshake and buffers one bit ahead. It holds each symbol for a configurable number of full carrier periods and drives the phase accumulator's enable, clear, step and sign-invert controls. Symbol changes occur only at carrier-period boundaries (accumulator wrap), so the carrier stays continuous for ASK (on-off keying), BPSK and BFSK.

---
 rtl/mod_symbol_scheduler.sv | 132 +++++++++++++
 tb/tb_mod_symbol_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_symbol_scheduler.sv
// rtl/mod_symbol_scheduler.sv - symbol timing and carrier control for the OOK/BPSK/BFSK modulator
// Symbols change only on carrier wraps so the accumulator phase stays continuous.
module mod_symbol_scheduler #(
  parameter int PERIODS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [PERIODS_W-1:0] periods,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  input  logic                 carrier_wrap,
  output logic                 acc_en,
  output logic                 acc_clr,
  output logic [1:0]           step,
  output logic                 invert,
  output logic                 amp_en,
  output logic                 sym_strobe,
  output logic                 busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_OOK  = 2'b00;
  localparam logic [1:0] MODE_BPSK = 2'b01;
  localparam logic [1:0] MODE_BFSK = 2'b10;

  logic [0:0]           state_q, state_d;
  logic                 buf_bit_q, buf_bit_d;
  logic                 buf_full_q, buf_full_d;
  logic                 cur_bit_q, cur_bit_d;
  logic [1:0]           cur_mode_q, cur_mode_d;
  logic [PERIODS_W-1:0] cur_periods_q, cur_periods_d;
  logic [PERIODS_W-1:0] per_cnt_q, per_cnt_d;
  logic                 sym_strobe_q, sym_strobe_d;

  logic load;
  logic last_period;

  always_comb begin
    state_d       = state_q;
    buf_bit_d     = buf_bit_q;
    buf_full_d    = buf_full_q;
    cur_bit_d     = cur_bit_q;
    cur_mode_d    = cur_mode_q;
    cur_periods_d = cur_periods_q;
    per_cnt_d     = per_cnt_q;
    sym_strobe_d  = 1'b0;
    load          = 1'b0;
    last_period   = (per_cnt_q == cur_periods_q - PERIODS_W'(1));

    if (state_q == ST_IDLE) begin
      load = buf_full_q;
    end else if (carrier_wrap) begin
      if (last_period) begin
        if (buf_full_q) load = 1'b1;
        else            state_d = ST_IDLE;
      end else begin
        per_cnt_d = per_cnt_q + PERIODS_W'(1);
      end
    end

    // Accept and load are exclusive: accept needs an empty buffer, load a full one.
    if (bit_valid && !buf_full_q) begin
      buf_bit_d  = bit_in;
      buf_full_d = 1'b1;
    end

    if (load) begin
      cur_bit_d     = buf_bit_q;
      cur_mode_d    = mode;
      cur_periods_d = (periods == '0) ? PERIODS_W'(1) : periods;
      per_cnt_d     = '0;
      buf_full_d    = 1'b0;
      sym_strobe_d  = 1'b1;
      state_d       = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      buf_bit_q     <= 1'b0;
      buf_full_q    <= 1'b0;
      cur_bit_q     <= 1'b0;
      cur_mode_q    <= MODE_OOK;
      cur_periods_q <= PERIODS_W'(1);
      per_cnt_q     <= '0;
      sym_strobe_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_bit_q     <= buf_bit_d;
      buf_full_q    <= buf_full_d;
      cur_bit_q     <= cur_bit_d;
      cur_mode_q    <= cur_mode_d;
      cur_periods_q <= cur_periods_d;
      per_cnt_q     <= per_cnt_d;
      sym_strobe_q  <= sym_strobe_d;
    end
  end

  always_comb begin
    acc_en  = 1'b0;
    acc_clr = 1'b1;
    step    = 2'd1;
    invert  = 1'b0;
    amp_en  = 1'b0;
    if (state_q == ST_RUN) begin
      acc_en  = 1'b1;
      acc_clr = 1'b0;
      case (cur_mode_q)
        MODE_OOK:  amp_en = cur_bit_q;
        MODE_BPSK: begin
          invert = !cur_bit_q;
          amp_en = 1'b1;
        end
        MODE_BFSK: begin
          step   = cur_bit_q ? 2'd2 : 2'd1;
          amp_en = 1'b1;
        end
        default:   amp_en = 1'b0;
      endcase
    end
  end

  assign bit_ready  = !buf_full_q;
  assign busy       = (state_q == ST_RUN);
  assign sym_strobe = sym_strobe_q;

endmodule

// File: tb/tb_mod_symbol_scheduler.sv
// tb/tb_mod_symbol_scheduler.sv - directed and randomized bench for mod_symbol_scheduler
module tb_mod_symbol_scheduler;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [PW-1:0] periods = PW'(1);
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready, carrier_wrap, acc_en, acc_clr, invert, amp_en, sym_strobe, busy;
  logic [1:0]    step;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  mod_symbol_scheduler #(.PERIODS_W(PW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .periods(periods),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .carrier_wrap(carrier_wrap), .acc_en(acc_en), .acc_clr(acc_clr),
    .step(step), .invert(invert), .amp_en(amp_en),
    .sym_strobe(sym_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  // 256-address phase accumulator: one carrier period is 256/step enabled cycles.
  int ph = 0;
  always @(posedge clk) begin
    if (rst || acc_clr) ph <= 0;
    else if (acc_en)    ph <= (ph + int'(step)) % 256;
  end
  assign carrier_wrap = acc_en && ((ph + int'(step)) >= 256);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected {step[1:0], invert, amp_en} for a symbol.
  function automatic logic [3:0] ctl_of(input logic [1:0] m, input logic b);
    case (m)
      2'd0:    return {2'd1, 1'b0, b};
      2'd1:    return {2'd1, !b, 1'b1};
      2'd2:    return {(b ? 2'd2 : 2'd1), 1'b0, 1'b1};
      default: return {2'd1, 1'b0, 1'b0};
    endcase
  endfunction

  logic          exp_bits[$];
  logic          inv_obs[$];
  int            gap_q[$];
  int            strobes = 0;
  int            idle_run = 0;
  bit            in_sym = 0;
  bit            bad = 0;
  int            sym_len = 0;
  int            exp_len = 0;
  int            pe = 0;
  logic [3:0]    ctl0, exp_ctl;
  logic          mb;
  logic [1:0]    prev_mode = 2'd0;
  logic [PW-1:0] prev_per = PW'(1);

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input string tag);
    bit_in = b;
    bit_valid = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bit_ready) begin
        @(posedge clk);
        #1;
        chk1({tag, "_ready_fall"}, bit_ready, 1'b0);
        return;
      end
    end
    chk1({tag, "_accept_timeout"}, bit_ready, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy && bit_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk1({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic bp[4];
    logic [7:0] bits8;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          exp_bits.delete();
          in_sym = 0;
          idle_run = 0;
        end else begin
          if (in_sym && (sym_strobe || !busy)) begin
            chk("sym_len", sym_len, exp_len);
            chk1("sym_steady", bad, 1'b0);
            in_sym = 0;
          end
          if (acc_clr) idle_run++;
          if (sym_strobe) begin
            strobes++;
            gap_q.push_back(idle_run);
            idle_run = 0;
            inv_obs.push_back(invert);
            chk1("sym_has_bit", exp_bits.size() > 0, 1'b1);
            if (exp_bits.size() > 0) begin
              mb = exp_bits.pop_front();
              exp_ctl = ctl_of(prev_mode, mb);
              pe = (prev_per == '0) ? 1 : int'(prev_per);
              exp_len = pe * 256 / int'(exp_ctl[3:2]);
              chk("sym_ctl", int'({step, invert, amp_en}), int'(exp_ctl));
              ctl0 = {step, invert, amp_en};
              in_sym = 1;
              sym_len = 1;
              bad = 0;
            end
          end else if (in_sym) begin
            sym_len++;
            if ({step, invert, amp_en} !== ctl0 || acc_en !== 1'b1 || acc_clr !== 1'b0) bad = 1;
          end
          if (bit_valid && bit_ready) exp_bits.push_back(bit_in);
        end
        prev_mode = mode;
        prev_per = periods;
      end
    join_none

    // Reset and idle
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_bit_ready", bit_ready, 1'b1);
    chk1("rst_acc_en", acc_en, 1'b0);
    chk1("rst_acc_clr", acc_clr, 1'b1);
    chk("rst_step", int'(step), 1);
    chk1("rst_invert", invert, 1'b0);
    chk1("rst_amp_en", amp_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_sym_strobe", sym_strobe, 1'b0);
    cycles(30);
    chk1("idle_bit_ready", bit_ready, 1'b1);
    chk1("idle_acc_clr", acc_clr, 1'b1);
    chk1("idle_acc_en", acc_en, 1'b0);
    chk1("idle_busy", busy, 1'b0);

    // OOK single symbol, 2 periods
    mode = 2'd0;
    periods = PW'(2);
    s0 = strobes;
    send_bit(1'b1, "ook");
    bit_valid = 1'b0;
    chk1("ook_start_not_busy", busy, 1'b0);
    cycles(1);
    chk1("ook_start_busy", busy, 1'b1);
    chk1("ook_start_strobe", sym_strobe, 1'b1);
    chk1("ook_start_acc_en", acc_en, 1'b1);
    chk1("ook_start_amp", amp_en, 1'b1);
    chk1("ook_ready_back", bit_ready, 1'b1);
    wait_idle("ook");
    chk("ook_strobes", strobes - s0, 1);
    chk1("ook_end_acc_clr", acc_clr, 1'b1);
    chk1("ook_end_busy", busy, 1'b0);

    // BPSK back-to-back stream
    mode = 2'd1;
    periods = PW'(1);
    s0 = strobes;
    gap_q.delete();
    inv_obs.delete();
    bp = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) send_bit(bp[i], "bpsk");
    bit_valid = 1'b0;
    wait_idle("bpsk");
    chk("bpsk_strobes", strobes - s0, 4);
    chk("bpsk_inv_count", inv_obs.size(), 4);
    if (inv_obs.size() == 4 && gap_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk1($sformatf("bpsk_invert_%0d", i), inv_obs[i], !bp[i]);
      for (int i = 1; i < 4; i++) chk($sformatf("bpsk_gap_%0d", i), gap_q[i], 0);
    end

    // BFSK with periods=0
    mode = 2'd2;
    periods = PW'(0);
    s0 = strobes;
    send_bit(1'b0, "bfsk");
    send_bit(1'b1, "bfsk");
    bit_valid = 1'b0;
    wait_idle("bfsk");
    chk("bfsk_strobes", strobes - s0, 2);

    // Backpressure: valid held high, 8 random bits
    mode = 2'd1;
    periods = PW'(1);
    inv_obs.delete();
    bits8 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) periods = PW'($urandom_range(0, 2));
      send_bit(bits8[i], "bp");
    end
    bit_valid = 1'b0;
    wait_idle("bp");
    chk("bp_count", inv_obs.size(), 8);
    if (inv_obs.size() == 8)
      for (int i = 0; i < 8; i++) chk1($sformatf("bp_bit_%0d", i), !inv_obs[i], bits8[i]);

    // Randomized modes, periods, gaps and mid-symbol configuration changes
    for (int r = 0; r < 10; r++) begin
      mode = 2'($urandom_range(0, 3));
      periods = PW'($urandom_range(0, 3));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        send_bit(1'($urandom), "rnd");
        if ($urandom_range(0, 1) == 1) begin
          bit_valid = 1'b0;
          cycles(int'($urandom_range(0, 300)));
        end
        if ($urandom_range(0, 2) == 0) begin
          mode = 2'($urandom_range(0, 3));
          periods = PW'($urandom_range(0, 3));
        end
      end
      bit_valid = 1'b0;
      cycles(int'($urandom_range(0, 400)));
    end
    wait_idle("rnd");

    // Reset mid-symbol with the buffer full
    mode = 2'd1;
    periods = PW'(2);
    send_bit(1'b1, "mid");
    send_bit(1'b0, "mid");
    bit_valid = 1'b0;
    chk1("mid_buf_full", bit_ready, 1'b0);
    cycles(98);
    chk1("mid_running", busy, 1'b1);
    rst = 1'b1;
    s0 = strobes;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", bit_ready, 1'b1);
    chk1("mid_rst_acc_clr", acc_clr, 1'b1);
    chk1("mid_rst_acc_en", acc_en, 1'b0);
    cycles(700);
    chk("mid_no_replay", strobes - s0, 0);
    chk1("mid_final_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
